// File: rtl/mcdf_pkg.sv
// Shared types, constants and the packet-length decode used by the formatter block.
package mcdf_pkg;

    localparam int          LEN_W   = 7;
    localparam logic [1:0]  CH_NONE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_WAIT_ID,
        ST_REQ,
        ST_SEND
    } fmt_state_e;

    // Codes above 4 saturate at the largest packet size.
    function automatic logic [LEN_W-1:0] pkglen_decode(input logic [2:0] sel);
        logic [LEN_W-1:0] len;
        case (sel)
            3'd0:    len = 7'd4;
            3'd1:    len = 7'd8;
            3'd2:    len = 7'd16;
            3'd3:    len = 7'd32;
            default: len = 7'd64;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/formatter_if.sv
// Arbiter-side and downstream-side handshake bundle of the formatter.
interface formatter_if;

    logic                       a2f_val_i;
    logic [1:0]                 a2f_id_i;
    logic [31:0]                a2f_data_i;
    logic [2:0]                 a2f_pkglen_sel_i;
    logic                       a2f_end_i;
    logic                       f2a_id_req_o;
    logic                       f2a_ack_o;

    logic                       fmt_req_o;
    logic                       fmt_grant_i;
    logic [1:0]                 fmt_chid_o;
    logic [mcdf_pkg::LEN_W-1:0] fmt_length_o;
    logic                       fmt_val_o;
    logic [31:0]                fmt_data_o;
    logic                       fmt_start_o;
    logic                       fmt_end_o;
    logic                       fmt_timeout_o;

    modport master (
        input  a2f_val_i, a2f_id_i, a2f_data_i, a2f_pkglen_sel_i, a2f_end_i, fmt_grant_i,
        output f2a_id_req_o, f2a_ack_o, fmt_req_o, fmt_chid_o, fmt_length_o,
               fmt_val_o, fmt_data_o, fmt_start_o, fmt_end_o, fmt_timeout_o
    );

    modport slave (
        output a2f_val_i, a2f_id_i, a2f_data_i, a2f_pkglen_sel_i, a2f_end_i, fmt_grant_i,
        input  f2a_id_req_o, f2a_ack_o, fmt_req_o, fmt_chid_o, fmt_length_o,
               fmt_val_o, fmt_data_o, fmt_start_o, fmt_end_o, fmt_timeout_o
    );

endinterface

// File: rtl/fmt_watchdog.sv
// SEND-state idle watchdog: down-counter reloaded on every accepted word, fires on the
// TIMEOUT_CYC-th consecutive idle SEND cycle.
module fmt_watchdog #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic in_send_i,
    input  logic val_i,
    output logic expire_o
);

    localparam int               CNT_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] idle_cnt;
    logic             idle_cyc;

    assign idle_cyc = in_send_i && !val_i;
    assign expire_o = idle_cyc && (idle_cnt == '0);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            idle_cnt <= RELOAD;
        end else if (!idle_cyc || expire_o) begin
            idle_cnt <= RELOAD;
        end else begin
            idle_cnt <= idle_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/formatter.sv
// Packet formatter: arbitrates for a channel, then forwards granted words downstream with
// start/end framing. Define FMT_TIMEOUT_EN to add the SEND-state idle watchdog.
module formatter
    import mcdf_pkg::*;
#(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    formatter_if.master  bus
);

    // state    | meaning
    // ---------+--------------------------------------------------
    // ST_IDLE  | gap cycle between packets
    // ST_ARB   | one-cycle arbitration request to the arbiter
    // ST_WAIT_ID | arbiter answer: retry on CH_NONE, else latch header
    // ST_REQ   | request downstream, wait for grant
    // ST_SEND  | forward words until last word (or watchdog abort)

    fmt_state_e       state_q, state_d;

    logic [1:0]       chid_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;

    logic             val_q;
    logic [31:0]      data_q;
    logic             start_q;
    logic             end_q;
    logic             to_q;

    logic             accept;
    logic             last_word;
    logic             id_valid;
    logic             expire;

    assign accept    = (state_q == ST_SEND) && bus.a2f_val_i;
    assign last_word = accept && ((cnt_q == len_q - 1'b1) || bus.a2f_end_i);
    assign id_valid  = (state_q == ST_WAIT_ID) && (bus.a2f_id_i != CH_NONE);

`ifdef FMT_TIMEOUT_EN
    fmt_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .in_send_i (state_q == ST_SEND),
        .val_i     (bus.a2f_val_i),
        .expire_o  (expire)
    );
`else
    logic unused_timeout_cfg;

    assign expire             = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    state_d = ST_ARB;
            ST_ARB:     state_d = ST_WAIT_ID;
            ST_WAIT_ID: state_d = id_valid ? ST_REQ : ST_IDLE;
            ST_REQ:     if (bus.fmt_grant_i) state_d = ST_SEND;
            ST_SEND:    if (last_word || expire) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Header stays put until the next successful arbitration, i.e. past the end word.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            chid_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else if (id_valid) begin
            chid_q <= bus.a2f_id_i;
            len_q  <= pkglen_decode(bus.a2f_pkglen_sel_i);
            cnt_q  <= '0;
        end else if (accept) begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            val_q   <= 1'b0;
            data_q  <= '0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            val_q   <= accept;
            start_q <= accept && (cnt_q == '0);
            end_q   <= last_word || expire;
            to_q    <= expire;
            if (accept) begin
                data_q <= bus.a2f_data_i;
            end
        end
    end

    assign bus.f2a_id_req_o  = (state_q == ST_ARB);
    assign bus.f2a_ack_o     = accept;
    assign bus.fmt_req_o     = (state_q == ST_REQ);
    assign bus.fmt_chid_o    = chid_q;
    assign bus.fmt_length_o  = len_q;
    assign bus.fmt_val_o     = val_q;
    assign bus.fmt_data_o    = data_q;
    assign bus.fmt_start_o   = start_q;
    assign bus.fmt_end_o     = end_q;
    assign bus.fmt_timeout_o = to_q;

endmodule

// File: tb/tb_formatter.sv
// Randomized bench for formatter: a procedural packet-level model checked every cycle,
// plus directed scenarios with hand-computed counts.
`timescale 1ns/1ps
module tb_formatter;

    localparam int TO = 256;

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;
    always #5 clk_i = ~clk_i;

    formatter_if ifc ();

    formatter #(.TIMEOUT_CYC(TO)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (ifc)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int          len_tab [8] = '{4, 8, 16, 32, 64, 64, 64, 64};
    bit          e_val, e_start, e_end, e_to, in_rst;
    logic [31:0] e_data;
    logic [1:0]  e_chid = '0;
    logic [6:0]  e_len  = '0;

    task automatic cyc(input bit x_idreq, input bit x_req, input bit x_send);
        @(negedge clk_i);
        if (!rstn_i) begin
            in_rst = 1'b1;
            e_val = 0; e_start = 0; e_end = 0; e_to = 0; e_chid = '0; e_len = '0;
            chk("rst_id_req", ifc.f2a_id_req_o, 0);
            chk("rst_ack",    ifc.f2a_ack_o,    0);
            chk("rst_req",    ifc.fmt_req_o,    0);
            chk("rst_val",    ifc.fmt_val_o,    0);
            chk("rst_data",   ifc.fmt_data_o,   0);
            chk("rst_start",  ifc.fmt_start_o,  0);
            chk("rst_end",    ifc.fmt_end_o,    0);
            chk("rst_to",     ifc.fmt_timeout_o, 0);
            chk("rst_chid",   ifc.fmt_chid_o,   0);
            chk("rst_len",    ifc.fmt_length_o, 0);
            return;
        end
        chk("id_req",  ifc.f2a_id_req_o, x_idreq);
        chk("fmt_req", ifc.fmt_req_o,    x_req);
        chk("ack",     ifc.f2a_ack_o,    x_send & ifc.a2f_val_i);
        chk("val",     ifc.fmt_val_o,    e_val);
        chk("start",   ifc.fmt_start_o,  e_start);
        chk("end",     ifc.fmt_end_o,    e_end);
        chk("timeout", ifc.fmt_timeout_o, e_to);
        chk("chid",    ifc.fmt_chid_o,   e_chid);
        chk("length",  ifc.fmt_length_o, e_len);
        if (e_val) chk("data", ifc.fmt_data_o, e_data);
        e_val = 0; e_start = 0; e_end = 0; e_to = 0;
    endtask

    initial begin : model
        int n;
        int idle;
        bit last;
        forever begin
            in_rst = 1'b0;
            cyc(0, 0, 0); if (in_rst) continue;   // gap cycle
            cyc(1, 0, 0); if (in_rst) continue;   // arbitration pulse
            cyc(0, 0, 0); if (in_rst) continue;   // arbiter answer
            if (ifc.a2f_id_i == 2'b11) continue;
            e_chid = ifc.a2f_id_i;
            e_len  = 7'(len_tab[ifc.a2f_pkglen_sel_i]);
            do cyc(0, 1, 0); while (!in_rst && !ifc.fmt_grant_i);
            if (in_rst) continue;
            n = 0; idle = 0;
            forever begin
                cyc(0, 0, 1);
                if (in_rst) break;
                if (ifc.a2f_val_i) begin
                    last    = (n == int'(e_len) - 1) || ifc.a2f_end_i;
                    e_val   = 1; e_data = ifc.a2f_data_i;
                    e_start = (n == 0); e_end = last;
                    n++; idle = 0;
                    if (last) break;
                end else begin
`ifdef FMT_TIMEOUT_EN
                    idle++;
                    if (idle == TO) begin
                        e_end = 1; e_to = 1;
                        break;
                    end
`endif
                end
            end
        end
    end

    // ---------------- event monitor ----------------
    int         m_ack = 0, m_start = 0, m_end = 0, m_to = 0, m_idreq = 0, m_req = 0;
    logic [1:0] last_chid = '0;
    logic [6:0] last_len  = '0;

    always @(negedge clk_i) begin
        if (ifc.f2a_ack_o)    m_ack++;
        if (ifc.fmt_start_o)  m_start++;
        if (ifc.fmt_timeout_o) m_to++;
        if (ifc.f2a_id_req_o) m_idreq++;
        if (ifc.fmt_req_o)    m_req++;
        if (ifc.fmt_end_o) begin
            m_end++;
            last_chid = ifc.fmt_chid_o;
            last_len  = ifc.fmt_length_o;
        end
    end

    int b_ack, b_start, b_end, b_to, b_idreq, b_req;
    task automatic snap();
        b_ack = m_ack; b_start = m_start; b_end = m_end;
        b_to = m_to; b_idreq = m_idreq; b_req = m_req;
    endtask

    // ---------------- stimulus ----------------
    int id_mode = 3, sel_mode = 0, val_mode = 0, end_mode = 2, gdelay = -1;
    int req_run = 0;
    bit val_tog = 1'b0;

    task automatic tick();
        @(posedge clk_i);
        #1;
        req_run = ifc.fmt_req_o ? req_run + 1 : 0;
        ifc.a2f_id_i         = (id_mode >= 0) ? 2'(id_mode) : 2'($urandom_range(0, 3));
        ifc.a2f_pkglen_sel_i = (sel_mode >= 0) ? 3'(sel_mode) : 3'($urandom_range(0, 7));
        ifc.a2f_data_i       = $urandom;
        case (val_mode)
            1:       ifc.a2f_val_i = 1'b1;
            2:       begin val_tog = ~val_tog; ifc.a2f_val_i = val_tog; end
            3:       ifc.a2f_val_i = ((m_ack - b_ack) < 2);
            default: ifc.a2f_val_i = ($urandom_range(0, 9) < 7);
        endcase
        case (end_mode)
            0:       ifc.a2f_end_i = ($urandom_range(0, 19) == 0);
            1:       ifc.a2f_end_i = ifc.a2f_val_i && ((m_ack - b_ack) == 4);
            default: ifc.a2f_end_i = 1'b0;
        endcase
        ifc.fmt_grant_i = (gdelay >= 0) ? (req_run >= gdelay) : ($urandom_range(0, 2) == 0);
    endtask

    task automatic run_packet(input string name, input int budget);
        for (int i = 0; i < budget && (m_end - b_end) < 1; i++) tick();
        chk(name, ((m_end - b_end) >= 1), 1);
        id_mode = 3;
        repeat (4) tick();
    endtask

    initial begin : stim
        int snap_idreq;
        ifc.a2f_val_i = 0; ifc.a2f_id_i = 2'b11; ifc.a2f_data_i = '0;
        ifc.a2f_pkglen_sel_i = '0; ifc.a2f_end_i = 0; ifc.fmt_grant_i = 0;

        // no requester: arbitration pulse every 3 cycles, no downstream request
        repeat (3) tick();
        rstn_i = 1'b1;
        snap();
        repeat (9) tick();
        chk("noreq_idreq_pulses", m_idreq - b_idreq, 3);
        chk("noreq_fmt_req",      m_req - b_req,     0);

        // 4-word packet on channel 1, grant after 2 request cycles
        snap();
        id_mode = 1; sel_mode = 0; val_mode = 1; end_mode = 2; gdelay = 2;
        run_packet("p4_done", 100);
        chk("p4_acks",     m_ack - b_ack,     4);
        chk("p4_starts",   m_start - b_start, 1);
        chk("p4_ends",     m_end - b_end,     1);
        chk("p4_req_cyc",  m_req - b_req,     2);
        chk("p4_chid",     last_chid,         1);
        chk("p4_len",      last_len,          4);

        // sel 6 saturates to 64 words, val toggling
        snap();
        id_mode = 2; sel_mode = 6; val_mode = 2; gdelay = 1;
        run_packet("p64_done", 400);
        chk("p64_acks", m_ack - b_ack, 64);
        chk("p64_ends", m_end - b_end, 1);
        chk("p64_len",  last_len,      64);
        chk("p64_chid", last_chid,     2);

        // early end on the 5th valid word of a 16-word packet
        snap();
        id_mode = 0; sel_mode = 2; val_mode = 1; end_mode = 1; gdelay = 0;
        for (int i = 0; i < 100 && (m_end - b_end) < 1; i++) tick();
        chk("early_done", ((m_end - b_end) >= 1), 1);
        id_mode = 3;
        snap_idreq = m_idreq;
        repeat (4) tick();
        chk("early_acks",   m_ack - b_ack, 5);
        chk("early_len",    last_len,      16);
        chk("early_rearb",  (m_idreq - snap_idreq) >= 1, 1);

        // reset during word 10 of a 32-word packet
        snap();
        id_mode = 1; sel_mode = 3; val_mode = 1; end_mode = 2; gdelay = 0;
        for (int i = 0; i < 100 && (m_ack - b_ack) < 10; i++) tick();
        chk("mid_words_seen", m_ack - b_ack, 10);
        chk("mid_val_before", ifc.fmt_val_o, 1);
        rstn_i = 1'b0;
        #1;
        chk("async_val",  ifc.fmt_val_o,    0);
        chk("async_data", ifc.fmt_data_o,   0);
        chk("async_ack",  ifc.f2a_ack_o,    0);
        chk("async_chid", ifc.fmt_chid_o,   0);
        chk("async_len",  ifc.fmt_length_o, 0);
        id_mode = 3;
        repeat (3) tick();
        rstn_i = 1'b1;
        snap();
        repeat (3) tick();
        chk("post_rst_idreq", m_idreq - b_idreq, 1);

`ifdef FMT_TIMEOUT_EN
        // valid stops after two words: watchdog abort
        snap();
        id_mode = 1; sel_mode = 4; val_mode = 3; end_mode = 2; gdelay = 0;
        for (int i = 0; i < TO + 100 && (m_to - b_to) < 1; i++) tick();
        chk("wd_fired", m_to - b_to, 1);
        id_mode = 3; val_mode = 1;
        repeat (6) tick();
        chk("wd_acks", m_ack - b_ack, 2);
        chk("wd_ends", m_end - b_end, 1);
        chk("wd_to",   m_to - b_to,   1);
`endif

        // random traffic with occasional asynchronous resets
        snap();
        id_mode = -1; sel_mode = -1; val_mode = 0; end_mode = 0; gdelay = -1;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if ($urandom_range(0, 599) == 0) begin
                rstn_i = 1'b0;
                repeat (2) tick();
                rstn_i = 1'b1;
            end
        end
        chk("rand_packets_seen", (m_end - b_end) > 10, 1);
        id_mode = 3;
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
